spi_reg_ctrl: RTL and testbench

SPI-mode-0 write-only configuration slave that owns the five PWM control registers (output enables 15:0, PWM enables 15:0, duty cycle). It feeds the registers directly into pwm_peripheral. It sits in the TinyTapeout top level. SCLK, COPI and nCS arrive asynchronously on ui_in pins and are resynchronised into clk. Only complete, valid 16-bit write frames change register state.

---
 rtl/spi_reg_ctrl_pkg.sv | 10 +
 rtl/spi_reg_ctrl_if.sv | 8 +
 rtl/spi_reg_ctrl_sync.sv | 17 +
 rtl/spi_reg_ctrl.sv | 72 +++++++
 tb/tb_spi_reg_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// spi_cfg_pkg: register map and frame constants for the SPI configuration slave
package spi_cfg_pkg;
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
    localparam int         FRAME_BITS       = 16;
    localparam logic       RW_WRITE         = 1'b1;
endpackage

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: asynchronous SPI pin bundle (mode 0, write-only)
interface spi_reg_ctrl_if;
    logic sclk;
    logic copi;
    logic ncs;
    modport master (output sclk, copi, ncs);
    modport slave  (input sclk, copi, ncs);
endinterface

// File: rtl/spi_reg_ctrl_sync.sv
// sync_ff_chain: STAGES-deep resynchroniser with a selectable reset value
module sync_ff_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r_q;
    always_ff @(posedge clk) begin
        if (!rst_n) r_q <= {STAGES{RESET_VAL}};
        else        r_q <= {r_q[STAGES-2:0], d};
    end
    assign q = r_q[STAGES-1];
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI mode-0 write-only slave owning the five PWM control registers
module spi_reg_ctrl
    import spi_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_cfg_pkg::FRAME_BITS,
    parameter int MAX_ADDR    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_reg_ctrl_if.slave        spi,
    output logic [7:0]           en_reg_out_7_0,
    output logic [7:0]           en_reg_out_15_8,
    output logic [7:0]           en_reg_pwm_7_0,
    output logic [7:0]           en_reg_pwm_15_8,
    output logic [7:0]           pwm_duty_cycle,
    output logic                 wr_strobe
);
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam int AW    = $clog2(MAX_ADDR + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

    logic                  w_sclk_s, w_copi_s, w_ncs_s;
    logic                  r_sclk_d, r_ncs_d;
    logic                  w_sclk_rise, w_ncs_fall, w_ncs_rise, w_shift_en, w_commit;
    logic [6:0]            w_addr;
    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [7:0]            r_regs [0:MAX_ADDR];
    logic                  r_wr_strobe;

    sync_ff_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi.sclk), .q(w_sclk_s));
    sync_ff_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (.clk(clk), .rst_n(rst_n), .d(spi.copi), .q(w_copi_s));
    sync_ff_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d(spi.ncs),  .q(w_ncs_s));

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
    // a clock edge coinciding with the select edge is not part of the frame
    assign w_shift_en  = w_sclk_rise & ~w_ncs_s & ~w_ncs_fall;
    assign w_addr      = r_shift[FRAME_BITS-2 -: 7];
    assign w_commit    = w_ncs_rise && r_cnt == CNT_FULL && r_shift[FRAME_BITS-1] == RW_WRITE
                         && w_addr <= 7'(MAX_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_wr_strobe <= 1'b0;
            for (int a = 0; a <= MAX_ADDR; a++) r_regs[a] <= 8'h00;
        end else begin
            r_sclk_d    <= w_sclk_s;
            r_ncs_d     <= w_ncs_s;
            r_wr_strobe <= w_commit;
            if (w_shift_en) r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_s};
            if (w_ncs_s || w_ncs_fall) r_cnt <= '0;
            else if (w_sclk_rise)      r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
            for (int a = 0; a <= MAX_ADDR; a++)
                if (w_commit && w_addr == 7'(a)) r_regs[a] <= r_shift[7:0];
        end
    end

    assign en_reg_out_7_0  = r_regs[ADDR_EN_OUT_7_0[AW-1:0]];
    assign en_reg_out_15_8 = r_regs[ADDR_EN_OUT_15_8[AW-1:0]];
    assign en_reg_pwm_7_0  = r_regs[ADDR_EN_PWM_7_0[AW-1:0]];
    assign en_reg_pwm_15_8 = r_regs[ADDR_EN_PWM_15_8[AW-1:0]];
    assign pwm_duty_cycle  = r_regs[ADDR_PWM_DUTY[AW-1:0]];
    assign wr_strobe       = r_wr_strobe;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed plus randomized SPI frames checked against a register-map model
module tb_spi_reg_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] o_out_lo, o_out_hi, o_pwm_lo, o_pwm_hi, o_duty;
    logic       wr_strobe;
    int         n_chk = 0, n_fail = 0, n_strobe = 0, m_strobe = 0;
    logic [7:0] m_reg [5];

    spi_reg_ctrl_if spi ();

    spi_reg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .spi(spi.slave),
        .en_reg_out_7_0(o_out_lo), .en_reg_out_15_8(o_out_hi),
        .en_reg_pwm_7_0(o_pwm_lo), .en_reg_pwm_15_8(o_pwm_hi),
        .pwm_duty_cycle(o_duty), .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (wr_strobe) n_strobe++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".out_lo"}, 32'(o_out_lo), 32'(m_reg[0]));
        chk({tag, ".out_hi"}, 32'(o_out_hi), 32'(m_reg[1]));
        chk({tag, ".pwm_lo"}, 32'(o_pwm_lo), 32'(m_reg[2]));
        chk({tag, ".pwm_hi"}, 32'(o_pwm_hi), 32'(m_reg[3]));
        chk({tag, ".duty"},   32'(o_duty),   32'(m_reg[4]));
        chk({tag, ".strobes"}, 32'(n_strobe), 32'(m_strobe));
    endtask

    task automatic put_bit(input logic b);
        spi.copi = b;
        idle(5);
        spi.sclk = 1'b1;
        idle(5);
        spi.sclk = 1'b0;
    endtask

    // only a complete 16-bit write to an implemented address lands
    task automatic model(input logic [31:0] w, input int n);
        if (n == 16 && w[15] && w[14:8] <= 7'd4) begin
            m_reg[int'(w[14:8])] = w[7:0];
            m_strobe++;
        end
    endtask

    task automatic send(input logic [31:0] w, input int n, input int gap);
        spi.ncs = 1'b0;
        idle(5);
        for (int i = n - 1; i >= 0; i--) put_bit(w[i]);
        idle(5);
        spi.ncs = 1'b1;
        model(w, n);
        idle(gap);
    endtask

    initial begin
        logic [31:0] w;
        int          n;
        logic [6:0]  addr;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        idle(4);
        rst_n = 1'b1;
        idle(20);
        chk_regs("reset");

        w = 32'h80F0;
        spi.ncs = 1'b0;
        idle(5);
        for (int i = 15; i >= 0; i--) put_bit(w[i]);
        idle(5);
        spi.ncs = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("lat.edge1", 32'(o_out_lo), 32'h00);
        @(posedge clk); @(negedge clk);
        chk("lat.edge2", 32'(o_out_lo), 32'h00);
        @(posedge clk); @(negedge clk);
        chk("lat.edge3", 32'(o_out_lo), 32'hF0);
        chk("lat.strobe_on", 32'(wr_strobe), 32'h1);
        @(posedge clk); @(negedge clk);
        chk("lat.strobe_off", 32'(wr_strobe), 32'h0);
        model(w, 16);
        idle(4);
        chk_regs("single");

        send(32'h81CC, 16, 4);
        send(32'h8255, 16, 4);
        send(32'h83AA, 16, 4);
        send(32'h8480, 16, 8);
        chk_regs("b2b");
        chk("b2b.duty_const", 32'(o_duty), 32'h80);

        send(32'h04FF, 16, 6);
        chk_regs("inv.read");
        send(32'hB012, 16, 6);
        chk_regs("inv.addr");
        send(32'h8412 >> 1, 15, 6);
        chk_regs("inv.short");
        send(32'h18412, 17, 6);
        chk_regs("inv.long");

        w = 32'h8433;
        spi.ncs = 1'b0;
        idle(5);
        for (int i = 15; i >= 8; i--) put_bit(w[i]);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        idle(5);
        spi.ncs = 1'b1;
        idle(8);
        chk_regs("rst_mid");
        send(32'h8433, 16, 6);
        chk_regs("after_rst");

        for (int i = 0; i < 16; i++) put_bit(1'($urandom));
        idle(6);
        chk_regs("ncs_high_toggle");
        send(32'h8199, 16, 6);
        chk_regs("post_toggle");

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0:       n = 15;
                1:       n = 17;
                default: n = 16;
            endcase
            addr = ($urandom_range(0, 4) != 0) ? 7'($urandom_range(0, 5)) : 7'($urandom_range(5, 127));
            w = {15'($urandom), 1'($urandom_range(0, 3) != 0), addr, 8'($urandom)};
            send(w, n, 4 + $urandom_range(0, 4));
            idle(4);
            chk_regs($sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
